// File: rtl/ring_rx_arbiter_if.sv
// rtl/ring_rx_arbiter_if.sv - source/output handshake bundle for the ring node receive arbiter
interface ring_rx_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             left_valid;
  logic [WIDTH-1:0] left_data;
  logic             left_ready;
  logic             self_valid;
  logic [WIDTH-1:0] self_data;
  logic             self_ready;
  logic             right_valid;
  logic [WIDTH-1:0] right_data;
  logic             right_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_ready;

  // master: the sources plus the node controller; slave: the arbiter itself
  modport master (
    output left_valid, left_data, self_valid, self_data,
    output right_valid, right_data, out_ready,
    input  left_ready, self_ready, right_ready,
    input  out_valid, out_data, out_src
  );

  modport slave (
    input  left_valid, left_data, self_valid, self_data,
    input  right_valid, right_data, out_ready,
    output left_ready, self_ready, right_ready,
    output out_valid, out_data, out_src
  );
endinterface

// File: rtl/ring_rx_arbiter.sv
// rtl/ring_rx_arbiter.sv - buffered round-robin arbiter over left/self/right receive FIFOs
// Optional grant statistics counters are enabled by defining RX_ARB_STATS_EN.
module ring_rx_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ring_rx_arbiter_if.slave     rx
`ifdef RX_ARB_STATS_EN
  ,
  output logic [15:0]          grant_cnt_left,
  output logic [15:0]          grant_cnt_self,
  output logic [15:0]          grant_cnt_right
`endif
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
  localparam int             NSRC     = 3;

  // Source index 0 = left, 1 = self, 2 = right; matches the out_src encoding.
  logic             src_valid [NSRC];
  logic [WIDTH-1:0] src_data  [NSRC];
  logic             src_ready [NSRC];
  logic             push      [NSRC];
  logic             pop       [NSRC];

  logic [WIDTH-1:0] mem_q    [NSRC][DEPTH];
  logic [WIDTH-1:0] mem_d    [NSRC][DEPTH];
  logic [AW-1:0]    wr_ptr_q [NSRC];
  logic [AW-1:0]    wr_ptr_d [NSRC];
  logic [AW-1:0]    rd_ptr_q [NSRC];
  logic [AW-1:0]    rd_ptr_d [NSRC];
  logic [AW:0]      cnt_q    [NSRC];
  logic [AW:0]      cnt_d    [NSRC];

  logic [1:0]       rr_q, rr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;

  logic             load;
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic [2:0]       scan_sum;
  logic [1:0]       scan_idx;

  always_comb begin
    src_valid[0] = rx.left_valid;
    src_valid[1] = rx.self_valid;
    src_valid[2] = rx.right_valid;
    src_data[0]  = rx.left_data;
    src_data[1]  = rx.self_data;
    src_data[2]  = rx.right_data;
    for (int i = 0; i < NSRC; i++) begin
      src_ready[i] = (cnt_q[i] != CNT_FULL);
      push[i]      = src_valid[i] & src_ready[i];
    end
  end

  assign rx.left_ready  = src_ready[0];
  assign rx.self_ready  = src_ready[1];
  assign rx.right_ready = src_ready[2];

  // Scan left->self->right starting at the rr pointer; first non-empty FIFO wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    scan_sum    = 3'd0;
    scan_idx    = 2'd0;
    for (int k = 0; k < NSRC; k++) begin
      scan_sum = {1'b0, rr_q} + 3'(k);
      scan_idx = (scan_sum >= 3'd3) ? 2'(scan_sum - 3'd3) : scan_sum[1:0];
      if (!grant_found && (cnt_q[scan_idx] != '0)) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // The output register only reloads when empty or being drained this cycle.
  assign load = !out_valid_q | rx.out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_d        = rr_q;
    for (int i = 0; i < NSRC; i++) begin
      pop[i] = load & grant_found & (grant_idx == 2'(i));
    end
    if (load) begin
      if (grant_found) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[grant_idx][rd_ptr_q[grant_idx]];
        out_src_d   = grant_idx;
        rr_d        = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_src_d   = 2'd0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      mem_d[i]    = mem_q[i];
      wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
      cnt_d[i]    = cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = src_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSRC; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_q        <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        mem_q[i]    <= mem_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign rx.out_valid = out_valid_q;
  assign rx.out_data  = out_data_q;
  assign rx.out_src   = out_src_q;

`ifdef RX_ARB_STATS_EN
  logic [15:0] stat_q [NSRC];
  logic [15:0] stat_d [NSRC];

  // A grant is counted when the word actually leaves the output register.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      stat_d[i] = stat_q[i];
      if (out_valid_q && rx.out_ready && (out_src_q == 2'(i)) && (stat_q[i] != 16'hFFFF)) begin
        stat_d[i] = stat_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSRC; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        stat_q[i] <= stat_d[i];
      end
    end
  end

  assign grant_cnt_left  = stat_q[0];
  assign grant_cnt_self  = stat_q[1];
  assign grant_cnt_right = stat_q[2];
`endif

endmodule
